// File: rtl/i2c_cmd_sequencer.sv
// ---------------------------------------------------------------------------------------------
// i2c_cmd_sequencer
//
// Command-queue front end for an I2C master. Host register-access commands are buffered in a
// small FIFO and launched one at a time on the master's en/addr/rw/mem_addr/data_wr inputs.
// For each command the sequencer waits for the master's busy pulse to complete, captures
// data_rd and ack_err, and returns exactly one response on a valid/ready channel. Responses
// leave in command order.
//
// Build option:
//   I2C_SEQ_RETRY_EN  When defined, a NACKed command is relaunched after RETRY_GAP idle cycles,
//                     up to MAX_RETRIES times. When undefined, a NACK is reported immediately
//                     and rsp_retries is always 0.
//
// Parameters:
//   DEPTH           command FIFO depth (power of two, >= 2)
//   LAUNCH_TIMEOUT  cycles to wait for m_busy after m_en is raised
//   MAX_RETRIES     NACK retries per command (retry build only)
//   RETRY_GAP       idle cycles between a NACK and the relaunch (retry build only)
//
// Ports:
//   clk, rst        clock; asynchronous active-low reset
//   cmd_*           command push channel (valid/ready) with addr, rw (1 = write), mem_addr, data
//   rsp_*           response channel (valid/ready) with data, code (00 ok/01 nack/10 timeout),
//                   echoed mem_addr and retries consumed
//   m_en, m_addr, m_rw, m_mem_addr, m_data_wr   registered drive to the I2C master
//   m_data_rd, m_ack_err, m_busy                status from the I2C master
//   fifo_level      current FIFO occupancy
//   idle            FIFO empty, sequencer idle and no response pending
// ---------------------------------------------------------------------------------------------
module i2c_cmd_sequencer #(
  parameter int unsigned DEPTH          = 4,
  parameter int unsigned LAUNCH_TIMEOUT = 16,
  parameter int unsigned MAX_RETRIES    = 2,
  parameter int unsigned RETRY_GAP      = 8
) (
  input  logic                     clk,
  input  logic                     rst,

  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [6:0]               cmd_addr,
  input  logic                     cmd_rw,
  input  logic [4:0]               cmd_mem_addr,
  input  logic [7:0]               cmd_data,

  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [7:0]               rsp_data,
  output logic [1:0]               rsp_code,
  output logic [4:0]               rsp_mem_addr,
  output logic [1:0]               rsp_retries,

  output logic                     m_en,
  output logic [6:0]               m_addr,
  output logic                     m_rw,
  output logic [4:0]               m_mem_addr,
  output logic [7:0]               m_data_wr,
  input  logic [7:0]               m_data_rd,
  input  logic                     m_ack_err,
  input  logic                     m_busy,

  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     idle
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned LvlW = PtrW + 1;
  localparam int unsigned TmoW = $clog2(LAUNCH_TIMEOUT + 1);
  localparam int unsigned CmdW = 7 + 1 + 5 + 8;

  localparam logic [1:0] CodeOk      = 2'b00;
  localparam logic [1:0] CodeNack    = 2'b01;
  localparam logic [1:0] CodeTimeout = 2'b10;

  typedef enum logic [2:0] {
    StIdle,
    StLaunch,
    StWait,
    StResp,
    StGap
  } state_e;

  state_e state;

  // -------------------------------------------------------------------------------------------
  // Command FIFO
  // -------------------------------------------------------------------------------------------
  logic [CmdW-1:0] fifo_mem [DEPTH];
  logic [PtrW-1:0] wr_ptr;
  logic [PtrW-1:0] rd_ptr;
  logic            fifo_full;
  logic            fifo_empty;
  logic            push;
  logic            launch;
  logic [CmdW-1:0] head;

  assign fifo_full  = (fifo_level == LvlW'(DEPTH));
  assign fifo_empty = (fifo_level == '0);
  assign head       = fifo_mem[rd_ptr];

  // A stale or foreign transaction on the master (m_busy high) holds off the launch.
  assign launch = (state == StIdle) && !fifo_empty && !rsp_valid && !m_busy;

  // The slot freed by a launch can be refilled on the same edge, so a full FIFO still
  // accepts a command in the cycle it pops.
  assign cmd_ready = !fifo_full || launch;
  assign push      = cmd_valid && cmd_ready;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {cmd_addr, cmd_rw, cmd_mem_addr, cmd_data};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PtrW'(1);
      end
      if (launch) begin
        rd_ptr <= rd_ptr + PtrW'(1);
      end
      if (push && !launch) begin
        fifo_level <= fifo_level + LvlW'(1);
      end else if (!push && launch) begin
        fifo_level <= fifo_level - LvlW'(1);
      end
    end
  end

  // -------------------------------------------------------------------------------------------
  // Retry bookkeeping
  // -------------------------------------------------------------------------------------------
  logic [1:0] retries_now;
  logic       can_retry;

`ifdef I2C_SEQ_RETRY_EN
  localparam int unsigned GapW = $clog2(RETRY_GAP + 1);

  logic [1:0]      retry_cnt;
  logic [GapW-1:0] gap_cnt;

  assign retries_now = retry_cnt;
  assign can_retry   = (retry_cnt < 2'(MAX_RETRIES));
`else
  assign retries_now = 2'b00;
  assign can_retry   = 1'b0;
`endif

  // -------------------------------------------------------------------------------------------
  // Sequencer FSM; all master and response outputs are registered here.
  // -------------------------------------------------------------------------------------------
  logic [TmoW-1:0] tmo_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= StIdle;
      m_en         <= 1'b0;
      m_addr       <= '0;
      m_rw         <= 1'b0;
      m_mem_addr   <= '0;
      m_data_wr    <= '0;
      rsp_valid    <= 1'b0;
      rsp_data     <= '0;
      rsp_code     <= '0;
      rsp_mem_addr <= '0;
      rsp_retries  <= '0;
      tmo_cnt      <= '0;
`ifdef I2C_SEQ_RETRY_EN
      retry_cnt    <= '0;
      gap_cnt      <= '0;
`endif
    end else begin
      unique case (state)
        StIdle: begin
          if (launch) begin
            // The m_* registers double as the current-command register.
            {m_addr, m_rw, m_mem_addr, m_data_wr} <= head;
            m_en    <= 1'b1;
            tmo_cnt <= '0;
`ifdef I2C_SEQ_RETRY_EN
            retry_cnt <= '0;
`endif
            state   <= StLaunch;
          end
        end

        StLaunch: begin
          if (m_busy) begin
            m_en  <= 1'b0;
            state <= StWait;
          end else if (tmo_cnt == TmoW'(LAUNCH_TIMEOUT - 1)) begin
            // Timeouts are reported directly and never retried.
            m_en         <= 1'b0;
            rsp_valid    <= 1'b1;
            rsp_code     <= CodeTimeout;
            rsp_data     <= '0;
            rsp_mem_addr <= m_mem_addr;
            rsp_retries  <= retries_now;
            state        <= StResp;
          end else begin
            tmo_cnt <= tmo_cnt + TmoW'(1);
          end
        end

        StWait: begin
          if (!m_busy) begin
            if (m_ack_err && can_retry) begin
`ifdef I2C_SEQ_RETRY_EN
              gap_cnt <= '0;
`endif
              state   <= StGap;
            end else begin
              rsp_valid    <= 1'b1;
              rsp_code     <= m_ack_err ? CodeNack : CodeOk;
              rsp_data     <= m_rw ? 8'h00 : m_data_rd;
              rsp_mem_addr <= m_mem_addr;
              rsp_retries  <= retries_now;
              state        <= StResp;
            end
          end
        end

        StResp: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= StIdle;
          end
        end

`ifdef I2C_SEQ_RETRY_EN
        StGap: begin
          if (gap_cnt == GapW'(RETRY_GAP - 1)) begin
            retry_cnt <= retry_cnt + 2'd1;
            m_en      <= 1'b1;
            tmo_cnt   <= '0;
            state     <= StLaunch;
          end else begin
            gap_cnt <= gap_cnt + GapW'(1);
          end
        end
`endif

        default: begin
          m_en  <= 1'b0;
          state <= StIdle;
        end
      endcase
    end
  end

  assign idle = fifo_empty && (state == StIdle) && !rsp_valid;

endmodule
